// File: rtl/rv32i_mem_stage.sv
// rtl/rv32i_mem_stage.sv - rv32i MEM stage: data-memory access, load alignment, MEM/WB register
package rv32i_core_pkg;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        wb_sel;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
  } ex_mem_payload_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] pc_plus4;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        wb_sel;
  } mem_wb_payload_t;

endpackage

module rv32i_mem_stage
  import rv32i_core_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_valid_i,
  input  ex_mem_payload_t ex_payload_i,
  output logic            ex_ready_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [31:0]     dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [31:0]     dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [31:0]     dmem_rdata_i,
  output logic            mem_valid_o,
  output mem_wb_payload_t mem_payload_o,
  output logic            mem_fault_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  state_t      state_q;
  logic [1:0]  off;
  logic [2:0]  f3;
  logic        is_store;
  logic        is_load;
  logic        is_mem;
  logic        acc_fault;
  logic        legal_mem;
  logic        accept;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // A store wins if EX ever flags both read and write.
  assign off       = ex_payload_i.alu_result[1:0];
  assign f3        = ex_payload_i.funct3;
  assign is_store  = ex_payload_i.mem_write;
  assign is_load   = ex_payload_i.mem_read && !ex_payload_i.mem_write;
  assign is_mem    = ex_payload_i.mem_read || ex_payload_i.mem_write;
  assign legal_mem = ex_valid_i && is_mem && !acc_fault;
  assign accept    = ex_valid_i && ex_ready_o;

  // Misalignment and illegal-funct3 detection for the instruction at the input.
  always_comb begin
    acc_fault = 1'b0;
    if (is_store) begin
      case (f3)
        3'b000:  acc_fault = 1'b0;
        3'b001:  acc_fault = off[0];
        3'b010:  acc_fault = (off != 2'b00);
        default: acc_fault = 1'b1;
      endcase
    end else if (is_load) begin
      case (f3)
        3'b000, 3'b100: acc_fault = 1'b0;
        3'b001, 3'b101: acc_fault = off[0];
        3'b010:         acc_fault = (off != 2'b00);
        default:        acc_fault = 1'b1;
      endcase
    end
  end

  // Byte enables and lane-replicated write data for stores.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = ex_payload_i.store_data;
    case (f3[1:0])
      2'b00: begin
        store_be    = 4'b0001 << off;
        store_wdata = {4{ex_payload_i.store_data[7:0]}};
      end
      2'b01: begin
        store_be    = off[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{ex_payload_i.store_data[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = ex_payload_i.store_data;
      end
    endcase
  end

  assign dmem_we_o    = is_store;
  assign dmem_addr_o  = {ex_payload_i.alu_result[31:2], 2'b00};
  assign dmem_be_o    = is_store ? store_be : 4'b0000;
  assign dmem_wdata_o = store_wdata;

  // Pick the addressed byte/halfword out of the returned word and extend it.
  always_comb begin
    case (off)
      2'b00:   ld_byte = dmem_rdata_i[7:0];
      2'b01:   ld_byte = dmem_rdata_i[15:8];
      2'b10:   ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  // Request and handshake decode; both forced low while reset is asserted.
  always_comb begin
    dmem_req_o = 1'b0;
    ex_ready_o = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          dmem_req_o = legal_mem;
          ex_ready_o = ex_valid_i && (!is_mem || acc_fault || (is_store && dmem_gnt_i));
        end
        WAIT_GNT: begin
          dmem_req_o = 1'b1;
          ex_ready_o = dmem_gnt_i && is_store;
        end
        WAIT_RVALID: begin
          ex_ready_o = dmem_rvalid_i;
        end
        default: begin
          dmem_req_o = 1'b0;
          ex_ready_o = 1'b0;
        end
      endcase
    end
  end

  // Transaction FSM and MEM/WB pipeline register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      mem_valid_o   <= 1'b0;
      mem_fault_o   <= 1'b0;
      mem_payload_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (legal_mem && !dmem_gnt_i)
            state_q <= WAIT_GNT;
          else if (legal_mem && is_load)
            state_q <= WAIT_RVALID;
        end
        WAIT_GNT: begin
          if (dmem_gnt_i)
            state_q <= is_load ? WAIT_RVALID : IDLE;
        end
        WAIT_RVALID: begin
          if (dmem_rvalid_i)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      mem_valid_o <= accept;
      if (accept) begin
        mem_fault_o              <= is_mem && acc_fault;
        mem_payload_o.alu_result <= ex_payload_i.alu_result;
        mem_payload_o.mem_rdata  <= (is_load && !acc_fault) ? ld_data : 32'h0;
        mem_payload_o.pc_plus4   <= ex_payload_i.pc_plus4;
        mem_payload_o.rd_addr    <= ex_payload_i.rd_addr;
        mem_payload_o.reg_write  <= ex_payload_i.reg_write && !(is_mem && acc_fault);
        mem_payload_o.wb_sel     <= ex_payload_i.wb_sel;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// tb/tb_rv32i_mem_stage.sv - scoreboard bench for rv32i_mem_stage
module tb_rv32i_mem_stage;
  import rv32i_core_pkg::*;

  typedef struct {
    mem_wb_payload_t p;
    logic            fault;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ex_valid = 1'b0;
  ex_mem_payload_t ex_payload = '0;
  logic            ex_ready;
  logic            dmem_req, dmem_we;
  logic [31:0]     dmem_addr, dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_gnt = 1'b0;
  logic            dmem_rvalid = 1'b0;
  logic [31:0]     dmem_rdata = '0;
  logic            mem_valid;
  mem_wb_payload_t mem_payload;
  logic            mem_fault;

  int checks = 0;
  int failures = 0;

  exp_t        sb_q[$];
  bus_t        bus_q[$];
  logic [31:0] ld_q[$];

  int gnt_delay = -1;
  int rv_delay  = -1;

  rv32i_mem_stage dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ex_valid_i   (ex_valid),
    .ex_payload_i (ex_payload),
    .ex_ready_o   (ex_ready),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_be_o    (dmem_be),
    .dmem_wdata_o (dmem_wdata),
    .dmem_gnt_i   (dmem_gnt),
    .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i (dmem_rdata),
    .mem_valid_o  (mem_valid),
    .mem_payload_o(mem_payload),
    .mem_fault_o  (mem_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Reference model: access size from funct3, fault from alignment, shifts for lanes.
  function automatic void model(input ex_mem_payload_t p, input logic [31:0] rd,
                                output exp_t e, output bit has_bus, output bus_t b);
    int          size;
    int          off;
    bit          is_mem, illegal, flt;
    logic [31:0] sh, v;
    size    = 1 << p.funct3[1:0];
    off     = int'(p.alu_result[1:0]);
    is_mem  = p.mem_read || p.mem_write;
    illegal = p.mem_write ? (p.funct3 > 3'd2) : (p.funct3 == 3'd3 || p.funct3 >= 3'd6);
    flt     = is_mem && (illegal || (off % size) != 0);
    sh      = rd >> (8 * off);
    if (size == 1) begin
      v = sh & 32'hFF;
      if (!p.funct3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = sh & 32'hFFFF;
      if (!p.funct3[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    e.fault          = flt;
    e.p.alu_result   = p.alu_result;
    e.p.mem_rdata    = (p.mem_read && !flt) ? v : 32'h0;
    e.p.pc_plus4     = p.pc_plus4;
    e.p.rd_addr      = p.rd_addr;
    e.p.reg_write    = p.reg_write && !flt;
    e.p.wb_sel       = p.wb_sel;
    has_bus          = is_mem && !flt;
    b.addr           = p.alu_result & 32'hFFFF_FFFC;
    b.we             = p.mem_write;
    b.be             = p.mem_write ? 4'(((1 << size) - 1) << off) : 4'b0000;
    if (size == 1)      b.wdata = 32'(p.store_data[7:0]) * 32'h0101_0101;
    else if (size == 2) b.wdata = 32'(p.store_data[15:0]) * 32'h0001_0001;
    else                b.wdata = p.store_data;
  endfunction

  task automatic push_expect(input ex_mem_payload_t p, input logic [31:0] rd, input bit to_sb);
    exp_t e;
    bit   hb;
    bus_t b;
    model(p, rd, e, hb, b);
    if (to_sb) sb_q.push_back(e);
    if (hb) bus_q.push_back(b);
    if (hb && p.mem_read) ld_q.push_back(rd);
  endtask

  // Called just after a rising edge; returns just after the edge that accepts.
  task automatic issue(input ex_mem_payload_t p, input logic [31:0] rd);
    bit ok = 0;
    push_expect(p, rd, 1);
    ex_payload = p;
    ex_valid   = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ex_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout actual=no_ready expected=ready at %0t", $time);
      finish_run();
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  function automatic ex_mem_payload_t mk(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                                          input logic [31:0] addr, input logic [31:0] sd,
                                          input logic [4:0] rd);
    ex_mem_payload_t p;
    p.alu_result = addr;
    p.store_data = sd;
    p.pc_plus4   = $urandom;
    p.rd_addr    = rd;
    p.reg_write  = rd_op || (!wr_op);
    p.wb_sel     = rd_op;
    p.mem_read   = rd_op;
    p.mem_write  = wr_op;
    p.funct3     = f3;
    return p;
  endfunction

  // Monitor: every MEM/WB pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mem_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_mem_valid actual=1 expected=0 at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("mem_fault", 32'(mem_fault), 32'(e.fault));
          check("alu_result", mem_payload.alu_result, e.p.alu_result);
          check("mem_rdata", mem_payload.mem_rdata, e.p.mem_rdata);
          check("pc_plus4", mem_payload.pc_plus4, e.p.pc_plus4);
          check("rd_addr", 32'(mem_payload.rd_addr), 32'(e.p.rd_addr));
          check("reg_write", 32'(mem_payload.reg_write), 32'(e.p.reg_write));
          check("wb_sel", 32'(mem_payload.wb_sel), 32'(e.p.wb_sel));
        end
      end
    end
  end

  // Memory responder: grants, returns load data, injects stray rvalids, checks the bus.
  initial begin
    int          wcnt = 0;
    int          rv_cnt = 0;
    logic [31:0] rd_pend = '0;
    bit          hold_v = 0;
    bus_t        hold, b;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        dmem_gnt = 0; dmem_rvalid = 0; rv_cnt = 0; wcnt = 0; hold_v = 0;
        continue;
      end
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rd_pend; end
      end else if ($urandom_range(0, 3) == 0) begin
        dmem_rvalid = 1'b1;
      end
      if (hold_v) begin
        check("req_held", 32'(dmem_req), 32'd1);
        check("addr_stable", dmem_addr, hold.addr);
        check("be_stable", 32'(dmem_be), 32'(hold.be));
        check("we_stable", 32'(dmem_we), 32'(hold.we));
      end
      hold_v = 0;
      dmem_gnt = 1'b0;
      if (dmem_req) begin
        dmem_gnt = (gnt_delay >= 0) ? (wcnt >= gnt_delay) : ($urandom_range(0, 2) != 0);
        if (dmem_gnt) begin
          wcnt = 0;
          checks++;
          if (bus_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_request actual=addr_0x%08h expected=no_req at %0t", dmem_addr, $time);
          end else begin
            b = bus_q.pop_front();
            check("dmem_addr", dmem_addr, b.addr);
            check("dmem_we", 32'(dmem_we), 32'(b.we));
            check("dmem_be", 32'(dmem_be), 32'(b.be));
            if (b.we) check("dmem_wdata", dmem_wdata, b.wdata);
            if (!dmem_we) begin
              rd_pend = (ld_q.size() > 0) ? ld_q.pop_front() : 32'h0;
              rv_cnt  = (rv_delay >= 0) ? rv_delay : $urandom_range(1, 3);
            end
          end
        end else begin
          wcnt++;
          hold_v = 1;
          hold.addr = dmem_addr; hold.be = dmem_be; hold.we = dmem_we;
        end
      end
      #1;
      if (rv_cnt > 0) check("ready_low_wait_rvalid", 32'(ex_ready), 32'd0);
    end
  end

  // Stimulus: reset checks, directed scenarios, mid-transaction reset, random traffic.
  initial begin
    ex_mem_payload_t p;
    exp_t            e;
    bit              hb;
    bus_t            b;

    ex_payload = mk(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd1);
    ex_valid   = 1'b1;
    #3;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_ready", 32'(ex_ready), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_fault", 32'(mem_fault), 32'd0);
    check("rst_payload_rdata", mem_payload.mem_rdata, 32'd0);
    check("rst_payload_alu", mem_payload.alu_result, 32'd0);
    ex_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD: ready in the same cycle, no request.
    gnt_delay = 0; rv_delay = 1;
    p = mk(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    issue(p, 32'h0);
    // SB with grant held low three cycles.
    gnt_delay = 3;
    issue(mk(1'b0, 1'b1, 3'b000, 32'h103, 32'hAB, 5'd0), 32'h0);
    // LH / LHU / LB with rvalid two cycles after grant.
    gnt_delay = 0; rv_delay = 2;
    issue(mk(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd6), 32'h8001_7FFF);
    issue(mk(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd7), 32'h8001_7FFF);
    issue(mk(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 5'd8), 32'h8001_7FFF);
    // Misaligned LW faults without a request.
    issue(mk(1'b1, 1'b0, 3'b010, 32'h206, 32'h0, 5'd9), 32'h0);
    // Back-to-back LW, SW, ADD.
    rv_delay = 1;
    issue(mk(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd10), 32'h1234_5678);
    issue(mk(1'b0, 1'b1, 3'b010, 32'h304, 32'hCAFE_F00D, 5'd0), 32'h0);
    issue(mk(1'b0, 1'b0, 3'b000, 32'h5555, 32'h0, 5'd11), 32'h0);

    // Reset while waiting for rvalid.
    rv_delay = 6;
    p = mk(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd12);
    push_expect(p, 32'h1111_2222, 0);
    ex_payload = p; ex_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0; ex_valid = 1'b0;
    #1;
    check("midrst_req", 32'(dmem_req), 32'd0);
    check("midrst_ready", 32'(ex_ready), 32'd0);
    check("midrst_mem_valid", 32'(mem_valid), 32'd0);
    check("midrst_rdata", mem_payload.mem_rdata, 32'd0);
    sb_q.delete(); bus_q.delete(); ld_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rv_delay = 1;
    issue(mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd13), 32'hDEAD_BEEF);
    repeat (3) @(posedge clk); #1;

    // Random traffic with random grant/rvalid latencies and gaps.
    gnt_delay = -1; rv_delay = -1;
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      p = mk(kind == 1, kind == 2, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom));
      p.reg_write = $urandom; p.wb_sel = $urandom;
      issue(p, $urandom);
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (10) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("bus_drained", 32'(bus_q.size()), 32'd0);
    finish_run();
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    finish_run();
  end

endmodule

// File: doc/rv32i_mem_stage.md
# rv32i_mem_stage

Memory-access stage of the rv32i five-stage pipeline, between EX and WB. Takes the EX/MEM payload, runs a single data-memory transaction over a req/gnt/rvalid bus for loads and stores, aligns and sign/zero-extends load data, and registers the result into the MEM/WB pipeline register that feeds the write-back stage. The stage stalls EX via a ready signal while a transaction is outstanding. WB never back-pressures.

## Interface
- No parameters. Payload types come from `rv32i_core_pkg`.
- `ex_mem_payload_t` fields: `alu_result[31:0]`, `store_data[31:0]`, `pc_plus4[31:0]`, `rd_addr[4:0]`, `reg_write`, `wb_sel`, `mem_read`, `mem_write`, `funct3[2:0]`.
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset, asynchronous assertion, active-low.
- `ex_valid_i`  in  1  EX/MEM payload valid. Must stay stable until accepted.
- `ex_payload_i`  in  ex_mem_payload_t  instruction from EX.
- `ex_ready_o`  out  1  instruction consumed this cycle. Accept occurs when `ex_valid_i && ex_ready_o`.
- `dmem_req_o`  out  1  memory request.
- `dmem_we_o`  out  1  1 = store.
- `dmem_addr_o`  out  32  word address, `{alu_result[31:2], 2'b00}`.
- `dmem_be_o`  out  4  byte enables. Stores only; 4'b0000 for loads.
- `dmem_wdata_o`  out  32  lane-replicated store data.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  load data valid. Arrives at least 1 cycle after gnt.
- `dmem_rdata_i`  in  32  load word.
- `mem_valid_o`  out  1  MEM/WB payload valid.
- `mem_payload_o`  out  mem_wb_payload_t  registered: `alu_result`, `mem_rdata`, `pc_plus4`, `rd_addr`, `reg_write`, `wb_sel`.
- `mem_fault_o`  out  1  registered with `mem_valid_o`. Flags a misaligned access or illegal funct3.

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE, no valid input: `ex_ready_o=0`, no request.
- IDLE, valid non-memory op (`!mem_read && !mem_write`): `ex_ready_o=1`. The payload is registered into MEM/WB at the next edge.
- IDLE, valid memory op with a fault: no request, `ex_ready_o=1`. Registered with `mem_valid_o=1`, `mem_fault_o=1`, `reg_write` forced to 0. Fault conditions:
  - LH/LHU/SH with `addr[0]=1`.
  - LW/SW with `addr[1:0]!=0`.
  - Load funct3 in {011,110,111}.
  - Store funct3 not in {000,001,010}.
- IDLE, valid legal memory op: `dmem_req_o=1` combinationally.
  - gnt in the same cycle, store: `ex_ready_o=1`, complete, stay IDLE.
  - gnt in the same cycle, load: go to WAIT_RVALID.
  - No gnt: go to WAIT_GNT.
- WAIT_GNT: `dmem_req_o` held high with stable addr/we/be/wdata until gnt. On gnt, a store completes (`ex_ready_o=1`, to IDLE) and a load goes to WAIT_RVALID.
- WAIT_RVALID: no request. On `dmem_rvalid_i`, the extracted data is registered, `ex_ready_o=1`, return to IDLE. Back-to-back requests from the same cycle are not allowed.
- Store data:
  - SB: `{4{b}}`, be = `4'b0001 << addr[1:0]`.
  - SH: `{2{h}}`, be = 4'b0011 or 4'b1100 by `addr[1]`.
  - SW: be = 4'b1111.
- Load extraction, byte lane selected by `addr[1:0]`:
  - LB: sign-extended byte. LBU: zero-extended byte.
  - LH/LHU: halfword at `addr[1]`, sign- or zero-extended.
  - LW: full word.
- On completion `mem_payload_o.mem_rdata` holds the extracted value. For non-loads it is 0. All other fields copy from the input.
- `mem_valid_o` is 1 for exactly one cycle per accepted instruction and 0 in every other cycle (bubble).

## Timing
- Reset values: state IDLE, `mem_valid_o=0`, `mem_fault_o=0`, `mem_payload_o` all zero. Combinational outputs while in reset: `dmem_req_o=0`, `ex_ready_o=0`.
- Non-memory op or fault accepted in cycle N: `mem_valid_o=1` in N+1.
- Store, gnt in cycle N+k: `mem_valid_o` in N+k+1.
- Load, rvalid in cycle M: `mem_valid_o` in M+1. Minimum load latency is 2 cycles.
- Reset mid-transaction: FSM returns to IDLE and the request drops immediately. A stale rvalid arriving after reset in IDLE is ignored; the memory is reset on the same signal.
- `dmem_rvalid_i` in IDLE or WAIT_GNT is ignored.

## Test plan
- ADD result 0x0000_1234, rd=5, valid in cycle 0 → `ex_ready_o=1` in cycle 0. Cycle 1: `mem_valid_o=1`, `alu_result=0x1234`, `mem_rdata=0`, no `dmem_req_o` ever.
- SB addr 0x103, store_data 0xAB, gnt held low 3 cycles → req held 4 cycles with addr 0x100, be 4'b1000, wdata 0xABABABAB. `mem_valid_o` one cycle after gnt.
- LH addr 0x102, gnt cycle 0, rvalid cycle 2, rdata 0x8001_7FFF → `mem_rdata=0xFFFF_8001` in cycle 3. LHU of the same gives 0x0000_8001. LB at 0x101 gives 0x0000_007F.
- LW addr 0x206 → no request, `mem_valid_o=1`, `mem_fault_o=1`, `reg_write=0` the next cycle.
- Load issued, gnt given, `rst_ni` low before rvalid → outputs reset immediately. After release a new LW at 0x10 with rdata 0xDEADBEEF completes correctly with `mem_valid_o` pulsing once.
- Back-to-back: LW, SW, ADD with zero-wait gnt and 1-cycle rvalid → three `mem_valid_o` pulses, in order, with `ex_ready_o` low during WAIT_RVALID.
